// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing controller.
// Holds the controller state enum, default timing constants and the
// lamp one-hot helper used for the violation check.
package ped_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      WALK  = 3'd2,
      FLASH = 3'd3,
      CLEAR = 3'd4
   } ped_state_e;

   localparam int unsigned WALK_TICKS_DEF   = 8;
   localparam int unsigned FLASH_TICKS_DEF  = 4;
   localparam int unsigned DEBOUNCE_CYC_DEF = 4;
   localparam int unsigned CNT_W_DEF        = 4;

   // True when exactly one vehicle lamp is lit.
   function automatic logic lamps_onehot(input logic g, input logic y, input logic r);
      case ({g, y, r})
         3'b100, 3'b010, 3'b001: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stability
// counter. The debounced level only follows the synchronized input after
// DEBOUNCE_CYC consecutive samples that differ from the current level.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   btn        - raw asynchronous button
//   level      - debounced button level
//   press      - one-cycle pulse on a rising edge of level
module btn_debounce
   import ped_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] stable_cnt;

   // Synchronizer, stability counter and registered press pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1    <= 1'b0;
         sync_q2    <= 1'b0;
         level      <= 1'b0;
         press      <= 1'b0;
         stable_cnt <= '0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
         press   <= 1'b0;
         if (sync_q2 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
            // This is the DEBOUNCE_CYC-th differing sample: accept it.
            level      <= sync_q2;
            press      <= sync_q2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ped_crossing.sv
// Pedestrian crossing controller downstream of the vehicle light FSM.
// Latches debounced button presses and grants a timed WALK phase while
// the vehicle light is red, followed by a flashing DON'T WALK clearance.
// Optional feature: define PED_CHIRP_EN to add the 'chirp' output.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   tick                   - one-cycle timing strobe
//   ped_btn                - raw pedestrian button
//   green, yellow, red     - vehicle lamp state
//   walk, dont_walk        - pedestrian lamps
//   req_pending            - latched request awaiting service
//   countdown              - ticks left in WALK/FLASH, else 0
//   violation              - sticky non-one-hot vehicle lamp flag
//   chirp (PED_CHIRP_EN)   - audible drive, toggles per tick in WALK
module ped_crossing
   import ped_pkg::*;
#(
   parameter int unsigned WALK_TICKS   = WALK_TICKS_DEF,
   parameter int unsigned FLASH_TICKS  = FLASH_TICKS_DEF,
   parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int unsigned CNT_W        = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             ped_btn,
   input  logic             green,
   input  logic             yellow,
   input  logic             red,
   output logic             walk,
   output logic             dont_walk,
   output logic             req_pending,
   output logic [CNT_W-1:0] countdown,
   output logic             violation
`ifdef PED_CHIRP_EN
   ,
   output logic             chirp
`endif
);

   ped_state_e       state;
   ped_state_e       state_d;
   logic             walk_d;
   logic             dont_walk_d;
   logic             req_d;
   logic [CNT_W-1:0] cnt_d;
   logic             violation_d;
   logic             btn_level;
   logic             btn_press;
   logic             press_c;
   logic             fault_c;
   logic             last_tick_c;
`ifdef PED_CHIRP_EN
   logic             chirp_d;
`endif

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_btn_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn   (ped_btn),
      .level (btn_level),
      .press (btn_press)
   );

   // Press pulse qualified by the settled level it reports.
   assign press_c     = btn_press & btn_level;
   assign violation_d = violation | ~lamps_onehot(green, yellow, red);
   assign fault_c     = violation_d;
   assign last_tick_c = tick && (countdown == CNT_W'(1));

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         walk        <= 1'b0;
         dont_walk   <= 1'b1;
         req_pending <= 1'b0;
         countdown   <= '0;
         violation   <= 1'b0;
`ifdef PED_CHIRP_EN
         chirp       <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         walk        <= walk_d;
         dont_walk   <= dont_walk_d;
         req_pending <= req_d;
         countdown   <= cnt_d;
         violation   <= violation_d;
`ifdef PED_CHIRP_EN
         chirp       <= chirp_d;
`endif
      end
   end

   // Next-state logic; lamp faults and red dropping override any tick.
   always_comb begin
      state_d = state;
      if (fault_c) begin
         state_d = CLEAR;
      end else begin
         case (state)
            IDLE:    if (press_c) state_d = ARMED;
            ARMED:   if (red) state_d = WALK;
            WALK: begin
               if (!red)             state_d = CLEAR;
               else if (last_tick_c) state_d = FLASH;
            end
            FLASH: begin
               if (!red || last_tick_c) state_d = CLEAR;
            end
            CLEAR: begin
               if (!red) state_d = (req_pending || press_c) ? ARMED : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output next values, derived from the state being entered.
   always_comb begin
      walk_d      = 1'b0;
      dont_walk_d = 1'b1;
      cnt_d       = '0;
      req_d       = req_pending;
`ifdef PED_CHIRP_EN
      chirp_d     = 1'b0;
`endif
      // A press in ARMED is already covered by the pending request.
      if (press_c && (state != ARMED)) req_d = 1'b1;

      case (state_d)
         WALK: begin
            walk_d      = 1'b1;
            dont_walk_d = 1'b0;
            if (state == ARMED) begin
               cnt_d = CNT_W'(WALK_TICKS);
               req_d = 1'b0;
            end else begin
               cnt_d = tick ? (countdown - CNT_W'(1)) : countdown;
`ifdef PED_CHIRP_EN
               chirp_d = chirp ^ tick;
`endif
            end
         end
         FLASH: begin
            if (state == WALK) begin
               cnt_d       = CNT_W'(FLASH_TICKS);
               dont_walk_d = 1'b1;
            end else begin
               cnt_d       = tick ? (countdown - CNT_W'(1)) : countdown;
               dont_walk_d = dont_walk ^ tick;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ped_crossing.sv
// Self-checking bench for ped_crossing: directed phases from the test plan
// followed by randomized press/tick/abort sequences whose expected lamp
// and countdown values are computed from tick counts.
module tb_ped_crossing;

   localparam int W   = 8;
   localparam int F   = 4;
   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       ped_btn = 1'b0;
   logic       green = 1'b1;
   logic       yellow = 1'b0;
   logic       red = 1'b0;
   logic       walk;
   logic       dont_walk;
   logic       req_pending;
   logic [3:0] countdown;
   logic       violation;
   logic       chirp;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ped_crossing #(
      .WALK_TICKS   (W),
      .FLASH_TICKS  (F),
      .DEBOUNCE_CYC (DEB),
      .CNT_W        (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .ped_btn     (ped_btn),
      .green       (green),
      .yellow      (yellow),
      .red         (red),
      .walk        (walk),
      .dont_walk   (dont_walk),
      .req_pending (req_pending),
      .countdown   (countdown),
      .violation   (violation)
`ifdef PED_CHIRP_EN
      ,
      .chirp       (chirp)
`endif
   );

`ifndef PED_CHIRP_EN
   assign chirp = 1'b0;
`endif

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int w, input int dw, input int cd);
      chk({tag, ".walk"}, int'(walk), w);
      chk({tag, ".dont_walk"}, int'(dont_walk), dw);
      chk({tag, ".countdown"}, int'(countdown), cd);
   endtask

   task automatic chk_chirp(input string tag, input int exp);
`ifdef PED_CHIRP_EN
      chk({tag, ".chirp"}, int'(chirp), exp);
`endif
   endtask

   // Advance n clock edges; inputs and samples sit 1 time unit after the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lamps(input logic g, input logic y, input logic r);
      green  = g;
      yellow = y;
      red    = r;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step(1);
      tick = 1'b0;
   endtask

   task automatic press_btn(input int hold);
      ped_btn = 1'b1;
      step(hold);
      ped_btn = 1'b0;
      step(10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  len, abort_at, nrun, gap;
      bit  exp_req;
      int  ew, edw, ecd, ech;

      // Reset state.
      step(2);
      chk_out("reset", 0, 1, 0);
      chk("reset.req", int'(req_pending), 0);
      chk("reset.violation", int'(violation), 0);
      chk_chirp("reset", 0);
      rst = 1'b0;

      // Button latency: 2 sync + DEB + 1 cycles.
      ped_btn = 1'b1;
      step(2 + DEB);
      chk("lat.before", int'(req_pending), 0);
      step(1);
      chk("lat.at", int'(req_pending), 1);
      ped_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick = 1'($urandom_range(0, 1));
         step(1);
      end
      tick = 1'b0;
      chk("armed.req", int'(req_pending), 1);
      chk_out("armed", 0, 1, 0);

      // Full WALK / FLASH / CLEAR cycle with random tick spacing.
      lamps(0, 0, 1);
      step(1);
      chk_out("walk.entry", 1, 0, W);
      chk("walk.entry.req", int'(req_pending), 0);
      for (int i = 1; i <= W; i++) begin
         step($urandom_range(0, 2));
         chk("walk.hold.cd", int'(countdown), W - i + 1);
         do_tick();
         if (i < W) begin
            chk_out("walk.tick", 1, 0, W - i);
            chk_chirp("walk.tick", i % 2);
         end else begin
            chk_out("flash.entry", 0, 1, F);
            chk_chirp("flash.entry", 0);
         end
      end
      for (int j = 1; j <= F; j++) begin
         step($urandom_range(0, 2));
         do_tick();
         if (j < F) chk_out("flash.tick", 0, (j % 2 == 0) ? 1 : 0, F - j);
         else       chk_out("clear.entry", 0, 1, 0);
         chk_chirp("flash.tick", 0);
      end
      step(3);
      chk_out("clear.hold", 0, 1, 0);
      lamps(1, 0, 0);
      step(2);
      chk_out("idle", 0, 1, 0);
      chk("idle.req", int'(req_pending), 0);
      chk_chirp("idle", 0);

      // Short glitches never produce a press.
      for (int g = 0; g < 3; g++) begin
         ped_btn = 1'b1;
         step($urandom_range(1, DEB - 1));
         ped_btn = 1'b0;
         step(12);
         chk("glitch.req", int'(req_pending), 0);
      end

      // Red drops after 3 WALK ticks; coincident tick is ignored.
      press_btn(DEB);
      lamps(0, 0, 1);
      step(1);
      for (int i = 0; i < 3; i++) do_tick();
      chk_out("abort.pre", 1, 0, W - 3);
      lamps(1, 0, 0);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      chk_out("abort", 0, 1, 0);
      chk_chirp("abort", 0);
      step(1);

      // Press during FLASH is served in the following red phase.
      press_btn(DEB);
      lamps(0, 0, 1);
      step(1);
      for (int i = 0; i < W; i++) do_tick();
      chk_out("f2.flash", 0, 1, F);
      press_btn($urandom_range(DEB, 8));
      chk("f2.req", int'(req_pending), 1);
      chk_out("f2.flash.hold", 0, 1, F);
      for (int i = 0; i < F; i++) do_tick();
      step(3);
      chk_out("f2.clear", 0, 1, 0);
      chk("f2.clear.req", int'(req_pending), 1);
      lamps(0, 1, 0);
      step(1);
      chk_out("f2.armed", 0, 1, 0);
      chk("f2.armed.req", int'(req_pending), 1);
      step(2);
      lamps(0, 0, 1);
      step(1);
      chk_out("f2.walk", 1, 0, W);
      chk("f2.walk.req", int'(req_pending), 0);

      // Lamp violation during WALK: sticky, WALK locked out.
      do_tick();
      do_tick();
      lamps(1, 0, 1);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      lamps(0, 0, 1);
      chk_out("viol", 0, 1, 0);
      chk("viol.flag", int'(violation), 1);
      for (int i = 0; i < 12; i++) begin
         tick = 1'($urandom_range(0, 1));
         if (i == 6) lamps(1, 0, 0);
         if (i == 9) lamps(0, 0, 1);
         step(1);
         chk("viol.walk", int'(walk), 0);
         chk("viol.sticky", int'(violation), 1);
      end
      tick = 1'b0;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("viol.rst", int'(violation), 0);
      chk_out("viol.rst", 0, 1, 0);

      // Reset mid-WALK drops the pending request.
      lamps(1, 0, 0);
      press_btn(DEB);
      lamps(0, 0, 1);
      step(1);
      do_tick();
      press_btn(DEB);
      chk("rstmid.req", int'(req_pending), 1);
      chk_out("rstmid.pre", 1, 0, W - 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk_out("rstmid", 0, 1, 0);
      chk("rstmid.req0", int'(req_pending), 0);
      step(3);
      chk("rstmid.stay", int'(walk), 0);
      lamps(1, 0, 0);
      step(12);

      // Randomized presses, tick spacing and abort points.
      for (int it = 0; it < 10; it++) begin
         len = $urandom_range(1, 8);
         exp_req = (len >= DEB);
         press_btn(len);
         chk("rnd.req", int'(req_pending), int'(exp_req));
         if (exp_req) begin
            lamps(0, 0, 1);
            step(1);
            chk_out("rnd.entry", 1, 0, W);
            abort_at = $urandom_range(1, W + F + 2);
            nrun = (abort_at - 1 < W + F) ? abort_at - 1 : W + F;
            for (int n = 1; n <= nrun; n++) begin
               gap = $urandom_range(0, 2);
               step(gap);
               do_tick();
               if (n < W) begin
                  ew = 1; edw = 0; ecd = W - n; ech = n % 2;
               end else if (n < W + F) begin
                  ew = 0; edw = ((n - W) % 2 == 0) ? 1 : 0; ecd = W + F - n; ech = 0;
               end else begin
                  ew = 0; edw = 1; ecd = 0; ech = 0;
               end
               chk_out("rnd.tick", ew, edw, ecd);
               chk_chirp("rnd.tick", ech);
            end
            lamps(1, 0, 0);
            tick = 1'($urandom_range(0, 1));
            step(1);
            tick = 1'b0;
            chk_out("rnd.end", 0, 1, 0);
            chk_chirp("rnd.end", 0);
            step(1);
            chk("rnd.idle.req", int'(req_pending), 0);
         end else begin
            step(3);
            chk("rnd.nowalk", int'(walk), 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
